// File: rtl/atm_controller.sv
// ATM transaction controller: a fixed table of accounts (PIN + balance).
// Each request is latched in IDLE, authenticated in AUTH, executed in one
// state, then held through DONE, so every transaction takes four cycles.
module atm_controller #(
  parameter int NUM_ACCOUNTS = 10,
  parameter int BAL_W        = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       operation,
  input  logic [3:0]       acc_num,
  input  logic [15:0]      pin,
  input  logic [15:0]      newPin,
  input  logic [BAL_W-1:0] amount,
  input  logic             language,
  output logic [BAL_W-1:0] balance,
  output logic             success,
  output logic [2:0]       state
);

  // The encoding is visible on the state port and read by the display
  // logic, so every code is fixed explicitly. Execution states share their
  // code with the operation they perform.
  typedef enum logic [2:0] {
    S_AUTH  = 3'd0,
    S_CHPIN = 3'd1,
    S_DONE  = 3'd2,
    S_BAL   = 3'd3,
    S_WDR   = 3'd4,
    S_DEP   = 3'd5,
    S_ERROR = 3'd6,
    S_IDLE  = 3'd7
  } state_t;

  state_t state_q, state_d;

  // Request captured in IDLE; everything after IDLE works only from these.
  logic [2:0]       op_q;
  logic [3:0]       acc_q;
  logic [15:0]      pin_q;
  logic [15:0]      new_pin_q;
  logic [BAL_W-1:0] amount_q;
  // Language select is held for the display front end; it never affects
  // the controller's own outputs.
  logic             language_unused_q;

  // Account table, slot i holds account number i+1.
  logic [15:0]      pin_tab [NUM_ACCOUNTS];
  logic [BAL_W-1:0] bal_tab [NUM_ACCOUNTS];

  logic             acc_ok;
  logic             op_ok;
  logic             auth_ok;
  logic [3:0]       idx;
  logic [15:0]      cur_pin;
  logic [BAL_W-1:0] cur_bal;
  logic [BAL_W:0]   dep_sum;
  logic [BAL_W-1:0] wdr_diff;

  // Factory PINs, restored on every reset.
  function automatic logic [15:0] default_pin(input int i);
    case (i)
      0:       return 16'd1234;
      1:       return 16'd2345;
      2:       return 16'd3456;
      3:       return 16'd4567;
      4:       return 16'd5678;
      5:       return 16'd6789;
      6:       return 16'd7890;
      7:       return 16'd8901;
      8:       return 16'd9012;
      9:       return 16'd7123;
      default: return 16'd0;
    endcase
  endfunction

  // Address decode, authentication and arithmetic on the latched request.
  always_comb begin
    acc_ok   = (int'(acc_q) >= 1) && (int'(acc_q) <= NUM_ACCOUNTS);
    op_ok    = op_q inside {3'd1, 3'd3, 3'd4, 3'd5};
    // Invalid account numbers are pointed at slot 0 so the table read is
    // always in range; acc_ok still blocks authentication for them.
    idx      = acc_ok ? (acc_q - 4'd1) : 4'd0;
    cur_pin  = pin_tab[idx];
    cur_bal  = bal_tab[idx];
    auth_ok  = acc_ok && op_ok && (cur_pin == pin_q);
    // One extra bit catches the carry out of a deposit.
    dep_sum  = {1'b0, cur_bal} + {1'b0, amount_q};
    wdr_diff = cur_bal - amount_q;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  // Next-state logic; defaults to holding the current state.
  always_comb begin
    // NOTE: a default on the first line of a combinational block keeps every
    // path assigned, so no latch can be inferred.
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (operation != 3'd0) state_d = S_AUTH;
      S_AUTH: begin
        if (!auth_ok) state_d = S_ERROR;
        else begin
          case (op_q)
            3'd1:    state_d = S_CHPIN;
            3'd3:    state_d = S_BAL;
            3'd4:    state_d = S_WDR;
            3'd5:    state_d = S_DEP;
            default: state_d = S_ERROR;
          endcase
        end
      end
      S_CHPIN, S_BAL, S_WDR, S_DEP, S_ERROR: state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Request capture, table updates and the result registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      // NOTE: the table is deliberately reset: reset must restore the factory
      // accounts, so it is built from registers rather than a RAM.
      for (int i = 0; i < NUM_ACCOUNTS; i++) begin
        pin_tab[i] <= default_pin(i);
        bal_tab[i] <= BAL_W'(1000 * (i + 1));
      end
      op_q              <= '0;
      acc_q             <= '0;
      pin_q             <= '0;
      new_pin_q         <= '0;
      amount_q          <= '0;
      language_unused_q <= 1'b0;
      balance           <= '0;
      success           <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (operation != 3'd0) begin
            op_q              <= operation;
            acc_q             <= acc_num;
            pin_q             <= pin;
            new_pin_q         <= newPin;
            amount_q          <= amount;
            language_unused_q <= language;
          end
        end
        S_BAL: begin
          balance <= cur_bal;
          success <= 1'b1;
        end
        S_WDR: begin
          if (amount_q <= cur_bal) begin
            bal_tab[idx] <= wdr_diff;
            balance      <= wdr_diff;
            success      <= 1'b1;
          end else begin
            balance <= cur_bal;
            success <= 1'b0;
          end
        end
        S_DEP: begin
          if (!dep_sum[BAL_W]) begin
            bal_tab[idx] <= dep_sum[BAL_W-1:0];
            balance      <= dep_sum[BAL_W-1:0];
            success      <= 1'b1;
          end else begin
            balance <= cur_bal;
            success <= 1'b0;
          end
        end
        S_CHPIN: begin
          pin_tab[idx] <= new_pin_q;
          balance      <= cur_bal;
          success      <= 1'b1;
        end
        S_ERROR: begin
          balance <= '0;
          success <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_atm_controller.sv
// Directed bench for atm_controller: a table of transactions with
// hand-computed results, plus sequences for idle hold and mid-transaction
// reset.
module tb_atm_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  operation;
  logic [3:0]  acc_num;
  logic [15:0] pin;
  logic [15:0] newPin;
  logic [31:0] amount;
  logic        language;
  logic [31:0] balance;
  logic        success;
  logic [2:0]  state;

  int errors = 0;
  int checks = 0;

  atm_controller dut (
    .clk       (clk),
    .rst       (rst),
    .operation (operation),
    .acc_num   (acc_num),
    .pin       (pin),
    .newPin    (newPin),
    .amount    (amount),
    .language  (language),
    .balance   (balance),
    .success   (success),
    .state     (state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [3:0]  acc;
    logic [15:0] pin;
    logic [15:0] new_pin;
    logic [31:0] amt;
    logic [2:0]  exec_st;
    logic [31:0] exp_bal;
    logic        exp_ok;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [15:0] factory_pin(input int a);
    case (a)
      1: return 16'd1234;  2: return 16'd2345;  3: return 16'd3456;
      4: return 16'd4567;  5: return 16'd5678;  6: return 16'd6789;
      7: return 16'd7890;  8: return 16'd8901;  9: return 16'd9012;
      default: return 16'd7123;
    endcase
  endfunction

  function automatic void add(input int op, input int acc, input int p,
                              input int np, input logic [31:0] amt,
                              input int st, input logic [31:0] bal,
                              input int ok);
    vec_t v;
    v.op = 3'(op); v.acc = 4'(acc); v.pin = 16'(p); v.new_pin = 16'(np);
    v.amt = amt; v.exec_st = 3'(st); v.exp_bal = bal; v.exp_ok = ok[0];
    vecs.push_back(v);
  endfunction

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Issue one request starting #1 after an edge with the DUT in IDLE, and
  // check the state walk and the results; ends #1 after the return to IDLE.
  task automatic run_vec(input vec_t v, input int n);
    string tag;
    tag = $sformatf("v%0d", n);
    operation = v.op; acc_num = v.acc; pin = v.pin;
    newPin = v.new_pin; amount = v.amt;
    @(posedge clk); #1;
    check({tag, " auth"}, 32'(state), 32'd0);
    // Inputs outside IDLE must be ignored.
    operation = 3'd5; acc_num = 4'd9; pin = 16'd9012; amount = 32'd77;
    @(posedge clk); #1;
    check({tag, " exec"}, 32'(state), 32'(v.exec_st));
    @(posedge clk); #1;
    check({tag, " done"}, 32'(state), 32'd2);
    check({tag, " bal"}, balance, v.exp_bal);
    check({tag, " ok"}, 32'(success), 32'(v.exp_ok));
    operation = 3'd0;
    @(posedge clk); #1;
    check({tag, " idle"}, 32'(state), 32'd7);
    check({tag, " bal hold"}, balance, v.exp_bal);
    check({tag, " ok hold"}, 32'(success), 32'(v.exp_ok));
  endtask

  initial begin
    // Show balance on every account.
    for (int a = 1; a <= 10; a++) add(3, a, factory_pin(a), 0, 0, 3, 32'(1000 * a), 1);
    // Deposit 1000 everywhere, then withdraw 500 everywhere.
    for (int a = 1; a <= 10; a++) add(5, a, factory_pin(a), 0, 1000, 5, 32'(1000 * a + 1000), 1);
    for (int a = 1; a <= 10; a++) add(4, a, factory_pin(a), 0, 500, 4, 32'(1000 * a + 500), 1);
    // Wrong PIN, then the account is untouched.
    add(4, 1, 1235, 0, 500, 6, 0, 0);
    add(3, 1, 1234, 0, 0, 3, 1500, 1);
    // Insufficient funds leaves the balance.
    add(4, 2, 2345, 0, 20000, 4, 2500, 0);
    // Bad account numbers and invalid operation codes.
    add(3, 0, 1234, 0, 0, 6, 0, 0);
    add(3, 11, 1234, 0, 0, 6, 0, 0);
    add(2, 1, 1234, 0, 0, 6, 0, 0);
    add(6, 1, 1234, 0, 0, 6, 0, 0);
    add(7, 1, 1234, 0, 0, 6, 0, 0);
    // PIN change on account 3.
    add(1, 3, 3456, 1111, 0, 1, 3500, 1);
    add(3, 3, 3456, 0, 0, 6, 0, 0);
    add(3, 3, 1111, 0, 0, 3, 3500, 1);
    // Withdraw the full balance, then zero amounts.
    add(4, 4, 4567, 0, 4500, 4, 0, 1);
    add(5, 4, 4567, 0, 0, 5, 0, 1);
    add(4, 6, 6789, 0, 0, 4, 6500, 1);
    // Deposit overflow by one, then a deposit landing exactly on all ones.
    add(5, 5, 5678, 0, 32'hFFFF_FFFF - 32'd5500 + 32'd1, 5, 5500, 0);
    add(5, 5, 5678, 0, 32'hFFFF_FFFF - 32'd5500, 5, 32'hFFFF_FFFF, 1);
    add(10 - 10 + 4, 10, 7123, 0, 32'd10501, 4, 10500, 0);

    rst = 1'b0; operation = 3'd0; acc_num = 4'd0; pin = 16'd0;
    newPin = 16'd0; amount = 32'd0; language = 1'b1;
    @(posedge clk); #1;
    check("reset state", 32'(state), 32'd7);
    check("reset bal", balance, 32'd0);
    check("reset ok", 32'(success), 32'd0);
    rst = 1'b1;

    foreach (vecs[i]) run_vec(vecs[i], i);

    // Idle with operation 0: state and outputs hold.
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      check("idle hold state", 32'(state), 32'd7);
      check("idle hold bal", balance, 32'd10500);
      check("idle hold ok", 32'(success), 32'd0);
    end

    // Reset during a PIN change: aborts it and restores the factory table.
    operation = 3'd1; acc_num = 4'd3; pin = 16'd1111; newPin = 16'd2222;
    @(posedge clk); #1;
    operation = 3'd0;
    @(posedge clk); #1;
    check("mid chpin state", 32'(state), 32'd1);
    rst = 1'b0;
    @(posedge clk); #1;
    check("mid reset state", 32'(state), 32'd7);
    check("mid reset bal", balance, 32'd0);
    check("mid reset ok", 32'(success), 32'd0);
    rst = 1'b1;
    begin
      vec_t v;
      v = '{3'd3, 4'd3, 16'd3456, 16'd0, 32'd0, 3'd3, 32'd3000, 1'b1};
      run_vec(v, 100);
      v = '{3'd3, 4'd3, 16'd2222, 16'd0, 32'd0, 3'd6, 32'd0, 1'b0};
      run_vec(v, 101);
      v = '{3'd3, 4'd1, 16'd1234, 16'd0, 32'd0, 3'd3, 32'd1000, 1'b1};
      run_vec(v, 102);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/atm_controller.md
Name: atm_controller

Overview:
- Single-clock ATM transaction controller holding a fixed table of 10 accounts (PIN + 32-bit balance).
- Each request (show balance, withdraw, deposit, change PIN) is authenticated against account number and PIN, then executed.
- Every transaction takes exactly 4 clock cycles, so a host can issue back-to-back requests every 4 cycles without pulsing reset.
- Sits behind the keypad/card front end; `balance`, `success` and `state` drive the display logic.

Parameters:
- NUM_ACCOUNTS, 10, number of account slots; account numbers 1..NUM_ACCOUNTS are valid.
- BAL_W, 32, width of balances and amounts.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  synchronous, active-low reset.
- operation  input  3  request code: 0 none, 1 change PIN, 3 show balance, 4 withdraw, 5 deposit; 2, 6 and 7 are invalid.
- acc_num  input  4  account number, valid 1..10.
- pin  input  16  PIN entered (binary value, e.g. 1234).
- newPin  input  16  replacement PIN for operation 1.
- amount  input  32  withdraw/deposit amount, unsigned.
- language  input  1  UI language select (0 English, 1 alternate); registered, no effect on outputs.
- balance  output  32  balance of the addressed account after the operation.
- success  output  1  1 = last transaction authenticated and completed.
- state  output  3  current FSM state encoding.

Behaviour:
- Reset (rst=0 at a rising edge):
  - state=7 (IDLE), balance=0, success=0.
  - Account table restored to defaults: acc 1..10 PIN = 1234, 2345, 3456, 4567, 5678, 6789, 7890, 8901, 9012, 7123; balance = 1000*acc_num (1000..10000).
  - Reset wins over any in-flight transaction; a partial transaction leaves no table change.
- State encoding: 7 IDLE, 0 AUTH, 1 CHPIN, 3 BAL, 4 WDR, 5 DEP, 6 ERROR, 2 DONE.
- IDLE:
  - operation==0: stay in IDLE.
  - Otherwise: latch operation, acc_num, pin, newPin and amount into internal registers, then go to AUTH.
  - Inputs are sampled only in IDLE; changes at other times are ignored.
- AUTH: pass requires acc_num in 1..10, stored PIN == latched pin, and operation in {1,3,4,5}.
  - Pass: go to the state with the same code as the operation.
  - Fail: go to ERROR.
- BAL: balance <= stored balance; success <= 1.
- WDR:
  - amount <= stored balance: stored -= amount; balance <= new value; success <= 1.
  - Otherwise: no change; balance <= stored balance; success <= 0.
  - Withdrawing exactly the full balance is allowed and leaves 0.
- DEP:
  - No 32-bit overflow: stored += amount; balance <= new value; success <= 1.
  - Overflow: no change; balance <= stored balance; success <= 0.
- CHPIN: stored PIN <= newPin; balance <= stored balance; success <= 1.
- ERROR: balance <= 0; success <= 0; no table change.
- All execution states (BAL, WDR, DEP, CHPIN, ERROR) go to DONE.
- DONE: outputs hold; go to IDLE.
- Latency and output hold:
  - Issue in IDLE at edge N; results are valid after edge N+2 and held through N+3.
  - The next request is sampled at edge N+4, so each transaction is 4 cycles.
  - balance and success hold their last values until overwritten by the next execution state.
- Amount 0: deposit or withdraw succeeds with the balance unchanged.
- Account table persists across transactions; it is only reinitialised by reset.

Test Plan:
- rst=0 for one edge -> state==7, balance==0, success==0.
- Show balance (op 3) for each of acc 1..10 with the default PIN, 4 cycles each -> balance == 1000*acc, success==1.
- Deposit 1000 (op 5) to each account, then withdraw 500 (op 4) from each, back-to-back -> balance 2000..11000 after deposits, then 1500..10500; state sequence 7,0,5/4,2,7.
- Wrong PIN (e.g. acc 1 with PIN 1235, op 4, amount 500) -> state passes through 6, success==0, balance==0; a later show balance on acc 1 still returns 1500.
- Withdraw 20000 from acc 2 -> success==0, balance unchanged; acc_num 0, acc_num 11 and op 2 -> ERROR.
- Change PIN acc 3 from 3456 to 1111, then show balance with 3456 -> fail, with 1111 -> pass; assert rst=0 mid-transaction -> state==7, PIN back to 3456.
